// File: rtl/bcd_display_driver.sv
// Four-digit multiplexed seven-segment driver for a BCD converter result.
// Captures a stable, synchronised result and scans it out one digit per refresh slot.

module bcd_display_driver #(
   parameter int unsigned REFRESH_DIV   = 50000,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [27:0] BCD_code,
   input  logic        BCD_ready,
   output logic [3:0]  anodes,
   output logic [6:0]  segments,
   output logic        display_valid,
   output logic        digit_error
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   typedef enum logic {
      WAIT_DATA = 1'b0,
      SCAN      = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          rdy_meta_q, rdy_meta_d;
   logic          rdy_s_q, rdy_s_d;
   logic [15:0]   samp_q, samp_d;
   logic [15:0]   samp_prev_q, samp_prev_d;
   logic [15:0]   disp_q, disp_d;
   logic          digit_error_q, digit_error_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    anodes_q, anodes_d;
   logic [6:0]    segments_q, segments_d;

   logic          capture;
   logic          slot_start;
   logic [3:0]    samp_bad;
   logic [3:0]    next_digit [4];
   logic [3:0]    next_blank;
   logic [3:0]    sel_digit;
   logic          sel_blank;
   logic          unused_low;

   assign unused_low = ^BCD_code[11:0];

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // Per-digit checks: validity of the sample, and blanking of the value about to be shown.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign samp_bad[gi]   = (samp_q[4*gi +: 4] > 4'd9);
         assign next_digit[gi] = disp_d[4*gi +: 4];
         if (gi == 0) begin : g_units
            assign next_blank[gi] = 1'b0;
         end else begin : g_upper
            assign next_blank[gi] = (BLANK_LEADING != 0) && (disp_d[15:4*gi] == '0);
         end
      end
   endgenerate

   // A result is accepted only once it has been seen unchanged on two consecutive edges.
   assign capture = rdy_s_q && (samp_q == samp_prev_q);

   always_comb begin
      rdy_meta_d    = BCD_ready;
      rdy_s_d       = rdy_meta_q;
      samp_d        = BCD_code[27:12];
      samp_prev_d   = samp_q;
      disp_d        = disp_q;
      digit_error_d = digit_error_q;
      if (capture) begin
         disp_d        = samp_q;
         digit_error_d = |samp_bad;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      anodes_d   = anodes_q;
      segments_d = segments_q;
      slot_start = 1'b0;
      sel_digit  = 4'd0;
      sel_blank  = 1'b0;

      case (state_q)
         WAIT_DATA: begin
            cnt_d      = '0;
            idx_d      = 2'd0;
            anodes_d   = 4'b1111;
            segments_d = 7'b1111111;
            if (capture) begin
               state_d    = SCAN;
               slot_start = 1'b1;
            end
         end
         SCAN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               idx_d      = idx_q + 2'd1;
               slot_start = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase

      // Drive lines only change at a slot boundary, so a capture mid-slot shows from the next slot.
      if (slot_start) begin
         sel_digit  = next_digit[idx_d];
         sel_blank  = next_blank[idx_d];
         anodes_d   = sel_blank ? 4'b1111 : ~(4'b0001 << idx_d);
         segments_d = sel_blank ? 7'b1111111 : seg_decode(sel_digit);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= WAIT_DATA;
         rdy_meta_q    <= 1'b0;
         rdy_s_q       <= 1'b0;
         samp_q        <= '0;
         samp_prev_q   <= '0;
         disp_q        <= '0;
         digit_error_q <= 1'b0;
         cnt_q         <= '0;
         idx_q         <= 2'd0;
         anodes_q      <= 4'b1111;
         segments_q    <= 7'b1111111;
      end else begin
         state_q       <= state_d;
         rdy_meta_q    <= rdy_meta_d;
         rdy_s_q       <= rdy_s_d;
         samp_q        <= samp_d;
         samp_prev_q   <= samp_prev_d;
         disp_q        <= disp_d;
         digit_error_q <= digit_error_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         anodes_q      <= anodes_d;
         segments_q    <= segments_d;
      end
   end

   assign anodes        = anodes_q;
   assign segments      = segments_q;
   assign display_valid = (state_q == SCAN);
   assign digit_error   = digit_error_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: two instances (leading blanking on/off) share all inputs.

module tb_bcd_display_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [27:0] code;
   logic        ready;
   logic [3:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;
   logic        valid_a, valid_b, err_a, err_b;

   int errors = 0;
   int checks = 0;
   int tick_n = 0;
   int base   = 0;

   always #5 clk = ~clk;

   bcd_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut_a (
      .clk(clk), .reset(reset), .BCD_code(code), .BCD_ready(ready),
      .anodes(an_a), .segments(seg_a), .display_valid(valid_a), .digit_error(err_a)
   );

   bcd_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(0)) dut_b (
      .clk(clk), .reset(reset), .BCD_code(code), .BCD_ready(ready),
      .anodes(an_b), .segments(seg_b), .display_valid(valid_b), .digit_error(err_b)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [3:0] digit_of(input logic [15:0] v, input int s);
      return v[4*s +: 4];
   endfunction

   function automatic logic blank_of(input logic [15:0] v, input int s, input logic bl);
      return bl && (s > 0) && ((v >> (4*s)) == 16'h0);
   endfunction

   function automatic logic [3:0] an_of(input logic [15:0] v, input int s, input logic bl);
      logic [3:0] one;
      one = 4'b0001;
      return blank_of(v, s, bl) ? 4'b1111 : ~(one << s);
   endfunction

   function automatic int slot_now();
      return ((tick_n - base) / DIV) % 4;
   endfunction

   task automatic tick();
      @(negedge clk);
      tick_n++;
   endtask

   task automatic set_code(input logic [15:0] v);
      code = {v, 12'h5A3};
   endtask

   task automatic align_slot();
      while (((tick_n - base) % DIV) != 0) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; ready = 1'b0; set_code(16'h0000);
      #1 reset = 1'b0;
      repeat (3) tick();
      checks++;
      if (an_a !== 4'b1111 || an_b !== 4'b1111) begin
         errors++; $display("FAIL reset_anodes: got %b/%b expected 1111", an_a, an_b);
      end
      checks++;
      if (seg_a !== 7'b1111111 || seg_b !== 7'b1111111) begin
         errors++; $display("FAIL reset_segments: got %b/%b expected 1111111", seg_a, seg_b);
      end
      checks++;
      if (valid_a !== 1'b0 || err_a !== 1'b0 || valid_b !== 1'b0 || err_b !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got valid=%b err=%b expected 0 0", valid_a, err_a);
      end
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++;
         if (an_a !== 4'b1111 || valid_a !== 1'b0 || an_b !== 4'b1111 || valid_b !== 1'b0) begin
            errors++; $display("FAIL idle_wait cycle %0d: got an=%b valid=%b expected 1111 0", i, an_a, valid_a);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_scan_basic();
      logic [3:0] exp_an  [4];
      logic [6:0] exp_seg [4];
      int lat;
      int s;
      exp_an[0] = 4'b1110; exp_seg[0] = 7'b0011001;
      exp_an[1] = 4'b1101; exp_seg[1] = 7'b0110000;
      exp_an[2] = 4'b1011; exp_seg[2] = 7'b0100100;
      exp_an[3] = 4'b0111; exp_seg[3] = 7'b1111001;
      set_code(16'h1234); ready = 1'b1;
      lat = 0;
      while (valid_a !== 1'b1 && lat < 8) begin tick(); lat++; end
      checks++;
      if (valid_a !== 1'b1 || lat > 4) begin
         errors++; $display("FAIL capture_latency: got %0d cycles valid=%b expected <=4 and 1", lat, valid_a);
      end
      base = tick_n;
      for (int i = 0; i < 16; i++) begin
         s = slot_now();
         checks++;
         if (an_a !== exp_an[s] || seg_a !== exp_seg[s] || an_b !== exp_an[s] || seg_b !== exp_seg[s]) begin
            errors++; $display("FAIL scan_1234 cycle %0d: got %b/%b expected %b/%b", i, an_a, seg_a, exp_an[s], exp_seg[s]);
         end
         checks++;
         if (valid_a !== 1'b1 || err_a !== 1'b0) begin
            errors++; $display("FAIL scan_1234_flags cycle %0d: got valid=%b err=%b expected 1 0", i, valid_a, err_a);
         end
         tick();
      end
      $display("test_scan_basic done");
   endtask

   task automatic test_error_digit();
      logic [15:0] old_v, v;
      int s;
      old_v = 16'h1234; v = 16'h00A5;
      align_slot();
      set_code(v);
      for (int k = 1; k <= 3; k++) begin
         tick();
         s = slot_now();
         checks++;
         if (an_a !== an_of(old_v, s, 1'b1) || seg_a !== seg_of(digit_of(old_v, s))) begin
            errors++; $display("FAIL hold_until_slot k=%0d: got %b/%b expected %b/%b", k, an_a, seg_a, an_of(old_v, s, 1'b1), seg_of(digit_of(old_v, s)));
         end
      end
      checks++;
      if (err_a !== 1'b1 || err_b !== 1'b1) begin
         errors++; $display("FAIL error_flag_latency: got %b/%b expected 1", err_a, err_b);
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         s = slot_now();
         checks++;
         if (an_a !== an_of(v, s, 1'b1)) begin
            errors++; $display("FAIL err_anode_a slot %0d: got %b expected %b", s, an_a, an_of(v, s, 1'b1));
         end
         if (!blank_of(v, s, 1'b1)) begin
            checks++;
            if (seg_a !== seg_of(digit_of(v, s))) begin
               errors++; $display("FAIL err_seg_a slot %0d: got %b expected %b", s, seg_a, seg_of(digit_of(v, s)));
            end
         end
         checks++;
         if (an_b !== an_of(v, s, 1'b0) || seg_b !== seg_of(digit_of(v, s))) begin
            errors++; $display("FAIL err_b slot %0d: got %b/%b expected %b/%b", s, an_b, seg_b, an_of(v, s, 1'b0), seg_of(digit_of(v, s)));
         end
         checks++;
         if (err_a !== 1'b1 || err_b !== 1'b1) begin
            errors++; $display("FAIL err_flag slot %0d: got %b/%b expected 1", s, err_a, err_b);
         end
         tick();
      end
      $display("test_error_digit done");
   endtask

   task automatic test_blanking();
      logic [15:0] old_v, v;
      int s;
      old_v = 16'h00A5; v = 16'h0007;
      align_slot();
      set_code(v);
      for (int k = 1; k <= 3; k++) begin
         tick();
         s = slot_now();
         checks++;
         if (an_a !== an_of(old_v, s, 1'b1)) begin
            errors++; $display("FAIL blank_hold k=%0d: got %b expected %b", k, an_a, an_of(old_v, s, 1'b1));
         end
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         s = slot_now();
         checks++;
         if (an_a !== an_of(v, s, 1'b1)) begin
            errors++; $display("FAIL blank_anode_a slot %0d: got %b expected %b", s, an_a, an_of(v, s, 1'b1));
         end
         if (s == 0) begin
            checks++;
            if (seg_a !== 7'b1111000) begin
               errors++; $display("FAIL blank_units_a: got %b expected 1111000", seg_a);
            end
         end
         checks++;
         if (an_b !== an_of(v, s, 1'b0) || seg_b !== seg_of(digit_of(v, s))) begin
            errors++; $display("FAIL noblank_b slot %0d: got %b/%b expected %b/%b", s, an_b, seg_b, an_of(v, s, 1'b0), seg_of(digit_of(v, s)));
         end
         checks++;
         if (err_a !== 1'b0) begin
            errors++; $display("FAIL blank_err_clear: got %b expected 0", err_a);
         end
         tick();
      end
      $display("test_blanking done");
   endtask

   task automatic test_ready_drop();
      logic [15:0] v;
      int s;
      v = 16'h0007;
      ready = 1'b0;
      for (int i = 0; i < 24; i++) begin
         tick();
         s = slot_now();
         checks++;
         if (valid_a !== 1'b1 || an_a !== an_of(v, s, 1'b1) || an_b !== an_of(v, s, 1'b0) || seg_b !== seg_of(digit_of(v, s))) begin
            errors++; $display("FAIL ready_drop cycle %0d: got valid=%b an=%b/%b expected 1 %b/%b", i, valid_a, an_a, an_b, an_of(v, s, 1'b1), an_of(v, s, 1'b0));
         end
      end
      $display("test_ready_drop done");
   endtask

   task automatic test_glitch_filter();
      logic [15:0] old_v, v;
      int s;
      old_v = 16'h0007; v = 16'h4095;
      align_slot();
      set_code(16'h1111); ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         s = slot_now();
         checks++;
         if (an_b !== an_of(old_v, s, 1'b0) || seg_b !== seg_of(digit_of(old_v, s)) || an_a !== an_of(old_v, s, 1'b1)) begin
            errors++; $display("FAIL toggle_hold cycle %0d: got %b/%b expected %b/%b", i, an_b, seg_b, an_of(old_v, s, 1'b0), seg_of(digit_of(old_v, s)));
         end
         set_code((i % 2 == 0) ? 16'h2222 : 16'h1111);
      end
      set_code(v);
      for (int k = 1; k <= 3; k++) begin
         tick();
         s = slot_now();
         checks++;
         if (an_b !== an_of(old_v, s, 1'b0) || seg_b !== seg_of(digit_of(old_v, s))) begin
            errors++; $display("FAIL stable_hold k=%0d: got %b/%b expected %b/%b", k, an_b, seg_b, an_of(old_v, s, 1'b0), seg_of(digit_of(old_v, s)));
         end
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         s = slot_now();
         checks++;
         if (an_a !== an_of(v, s, 1'b1) || seg_a !== seg_of(digit_of(v, s)) || an_b !== an_of(v, s, 1'b0) || seg_b !== seg_of(digit_of(v, s))) begin
            errors++; $display("FAIL show_4095 slot %0d: got %b/%b expected %b/%b", s, an_a, seg_a, an_of(v, s, 1'b1), seg_of(digit_of(v, s)));
         end
         checks++;
         if (err_a !== 1'b0) begin
            errors++; $display("FAIL show_4095_err: got %b expected 0", err_a);
         end
         tick();
      end
      $display("test_glitch_filter done");
   endtask

   task automatic test_reset_mid_scan();
      logic [15:0] v;
      int guard, lat, s;
      v = 16'h4095;
      guard = 0;
      while (!(slot_now() == 1 && ((tick_n - base) % DIV) == 1) && guard < 40) begin
         tick(); guard++;
      end
      checks++;
      if (an_a !== 4'b1101 || seg_a !== 7'b0010000) begin
         errors++; $display("FAIL tens_slot_before_reset: got %b/%b expected 1101/0010000", an_a, seg_a);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (an_a !== 4'b1111 || seg_a !== 7'b1111111 || an_b !== 4'b1111) begin
         errors++; $display("FAIL async_reset_outputs: got %b/%b expected 1111/1111111", an_a, seg_a);
      end
      checks++;
      if (valid_a !== 1'b0 || err_a !== 1'b0) begin
         errors++; $display("FAIL async_reset_flags: got valid=%b err=%b expected 0 0", valid_a, err_a);
      end
      ready = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (valid_a !== 1'b0 || an_a !== 4'b1111) begin
            errors++; $display("FAIL post_reset_wait cycle %0d: got valid=%b an=%b expected 0 1111", i, valid_a, an_a);
         end
      end
      ready = 1'b1;
      lat = 0;
      while (valid_a !== 1'b1 && lat < 8) begin tick(); lat++; end
      checks++;
      if (valid_a !== 1'b1 || lat > 4) begin
         errors++; $display("FAIL recapture_latency: got %0d cycles valid=%b expected <=4 and 1", lat, valid_a);
      end
      base = tick_n;
      for (int i = 0; i < 16; i++) begin
         s = slot_now();
         checks++;
         if (an_a !== an_of(v, s, 1'b1) || seg_a !== seg_of(digit_of(v, s))) begin
            errors++; $display("FAIL recapture_scan slot %0d: got %b/%b expected %b/%b", s, an_a, seg_a, an_of(v, s, 1'b1), seg_of(digit_of(v, s)));
         end
         tick();
      end
      $display("test_reset_mid_scan done");
   endtask

   initial begin
      test_reset();
      test_scan_basic();
      test_error_digit();
      test_blanking();
      test_ready_drop();
      test_glitch_filter();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
